// File: rtl/comma_code_sched.sv
// Round-robin scheduler that shares one bit-serial comma-code scanner among N_REQ requesters.
// The scanner reports the index of the lowest set bit with a valid/ready response tagged by requester ID.
module comma_code_sched #(
  parameter int N_REQ      = 4,
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_SIZE = 4,
  parameter int ID_SIZE    = 2
) (
  input  logic                        trigger,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WORD_SIZE-1:0]  word_bus,
  output logic [N_REQ-1:0]            ack,
  output logic                        busy,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_SIZE-1:0]          resp_id,
  output logic [INDEX_SIZE-1:0]       index_out,
  output logic                        found
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ID_SIZE-1:0]      rr_ptr;
  logic [ID_SIZE-1:0]      pick_id;
  logic [ID_SIZE-1:0]      gnt_id;
  logic                    req_any;
  logic [WORD_SIZE-1:0]    shreg;
  logic [INDEX_SIZE-1:0]   cnt;
  logic                    scan_hit;
  logic                    scan_end;

  // First set request at or above ptr, wrapping modulo N_REQ; lowest offset wins.
  function automatic logic [ID_SIZE-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [ID_SIZE-1:0] ptr);
    logic [ID_SIZE-1:0] pick;
    int idx;
    pick = ptr;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (r[idx]) pick = ID_SIZE'(idx);
    end
    return pick;
  endfunction

  function automatic logic [ID_SIZE-1:0] next_ptr(input logic [ID_SIZE-1:0] id);
    return ID_SIZE'((int'(id) + 1) % N_REQ);
  endfunction

  assign req_any  = |req;
  assign pick_id  = rr_pick(req, rr_ptr);
  assign scan_hit = shreg[0];
  assign scan_end = (cnt == INDEX_SIZE'(WORD_SIZE - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = SCAN;
      SCAN:    if (scan_hit || scan_end) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge trigger) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control and response registers: a reset discards any in-flight scan.
  always_ff @(posedge trigger) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      ack        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      index_out  <= '0;
      found      <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            ack    <= N_REQ'(1) << pick_id;
            rr_ptr <= next_ptr(pick_id);
          end
        end
        SCAN: begin
          if (scan_hit) begin
            found      <= 1'b1;
            index_out  <= cnt;
            resp_valid <= 1'b1;
            resp_id    <= gnt_id;
          end else if (scan_end) begin
            found      <= 1'b0;
            index_out  <= '0;
            resp_valid <= 1'b1;
            resp_id    <= gnt_id;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Scan datapath: only meaningful while SCAN, so it carries no reset.
  always_ff @(posedge trigger) begin
    if (state == IDLE && req_any) begin
      shreg  <= word_bus[int'(pick_id)*WORD_SIZE +: WORD_SIZE];
      gnt_id <= pick_id;
      cnt    <= '0;
    end else if (state == SCAN && !scan_hit && !scan_end) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_comma_code_sched.sv
// Directed self-checking bench for comma_code_sched: latency, round robin, backpressure, mid-scan reset.
module tb_comma_code_sched;
  localparam int N_REQ      = 4;
  localparam int WORD_SIZE  = 16;
  localparam int INDEX_SIZE = 4;
  localparam int ID_SIZE    = 2;

  logic                        trigger = 1'b0;
  logic                        rst_n;
  logic [N_REQ-1:0]            req;
  logic [N_REQ*WORD_SIZE-1:0]  word_bus;
  logic [N_REQ-1:0]            ack;
  logic                        busy;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [ID_SIZE-1:0]          resp_id;
  logic [INDEX_SIZE-1:0]       index_out;
  logic                        found;
  logic [WORD_SIZE-1:0]        words [N_REQ];

  int n_tot  = 0;
  int n_pass = 0;

  comma_code_sched #(
    .N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE), .INDEX_SIZE(INDEX_SIZE), .ID_SIZE(ID_SIZE)
  ) dut (
    .trigger(trigger), .rst_n(rst_n), .req(req), .word_bus(word_bus), .ack(ack),
    .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .index_out(index_out), .found(found)
  );

  always #5 trigger = ~trigger;

  always_comb begin
    word_bus = '0;
    for (int i = 0; i < N_REQ; i++) word_bus[i*WORD_SIZE +: WORD_SIZE] = words[i];
  end

  task automatic tick();
    @(posedge trigger);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Grant requester id, then wait (bounded) for the response and check latency and result.
  task automatic run_word(input int id, input logic [WORD_SIZE-1:0] w,
                          input int exp_idx, input int exp_found, input int exp_lat);
    int c;
    words[id] = w;
    req[id]   = 1'b1;
    tick();
    chk($sformatf("ack_r%0d", id), 32'(ack), 32'(1) << id);
    req[id] = 1'b0;
    c = 0;
    do begin
      tick();
      c++;
    end while (!resp_valid && c < 40);
    chk($sformatf("lat_r%0d", id), 32'(c), 32'(exp_lat));
    chk($sformatf("idx_r%0d", id), 32'(index_out), 32'(exp_idx));
    chk($sformatf("found_r%0d", id), 32'(found), 32'(exp_found));
    chk($sformatf("rid_r%0d", id), 32'(resp_id), 32'(id));
    tick();
    chk($sformatf("drop_r%0d", id), 32'(resp_valid), 32'(0));
    chk($sformatf("idle_r%0d", id), 32'(busy), 32'(0));
  endtask

  initial begin
    logic hold_ok;
    logic ack_seen;
    logic valid_seen;
    rst_n      = 1'b0;
    req        = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) words[i] = '0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(resp_valid), 32'(0));
    chk("rst_id", 32'(resp_id), 32'(0));
    chk("rst_idx", 32'(index_out), 32'(0));
    chk("rst_found", 32'(found), 32'(0));
    rst_n = 1'b1;

    // Single-word latency cases.
    run_word(0, 16'h0005, 0, 1, 1);
    run_word(1, 16'h0AA0, 5, 1, 6);
    run_word(2, 16'h0000, 0, 0, 16);

    // Round robin from a fresh pointer with all requests held.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    words[0] = 16'hF50F;
    words[1] = 16'h0AB7;
    words[2] = 16'h0A0F;
    words[3] = 16'hFFFF;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % N_REQ;
      tick();
      chk($sformatf("rr_ack%0d", i), 32'(ack), 32'(1) << g);
      req[g] = 1'b0;
      tick();
      chk($sformatf("rr_valid%0d", i), 32'(resp_valid), 32'(1));
      chk($sformatf("rr_id%0d", i), 32'(resp_id), 32'(g));
      chk($sformatf("rr_idx%0d", i), 32'(index_out), 32'(0));
      req[g] = 1'b1;
      tick();
      chk($sformatf("rr_done%0d", i), 32'(resp_valid), 32'(0));
    end
    req = '0;

    // Backpressure on requester 1 while requester 3 waits.
    words[1]   = 16'h0AA0;
    words[3]   = 16'hFFFF;
    resp_ready = 1'b0;
    req        = 4'b0010;
    tick();
    chk("bp_ack", 32'(ack), 32'(4'b0010));
    req = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_early", 32'(resp_valid), 32'(0));
    tick();
    chk("bp_valid", 32'(resp_valid), 32'(1));
    chk("bp_idx", 32'(index_out), 32'(5));
    chk("bp_id", 32'(resp_id), 32'(1));
    hold_ok  = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(resp_valid === 1'b1 && index_out === 4'd5 && resp_id === 2'd1 && found === 1'b1))
        hold_ok = 1'b0;
      if (ack !== '0) ack_seen = 1'b1;
    end
    chk("bp_hold", 32'(hold_ok), 32'(1));
    chk("bp_noack", 32'(ack_seen), 32'(0));
    resp_ready = 1'b1;
    tick();
    chk("bp_drop", 32'(resp_valid), 32'(0));
    chk("bp_drop_ack", 32'(ack), 32'(0));
    tick();
    chk("bp_next_ack", 32'(ack), 32'(4'b1000));
    req = '0;
    tick();
    chk("bp_next_id", 32'(resp_id), 32'(3));
    tick();

    // Mid-scan reset discards the word and resets the pointer.
    words[0] = 16'h8000;
    req      = 4'b0001;
    tick();
    chk("mr_ack", 32'(ack), 32'(4'b0001));
    req = '0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_valid", 32'(resp_valid), 32'(0));
    chk("mr_zero", 32'({ack, resp_id, index_out, found}), 32'(0));
    rst_n      = 1'b1;
    valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid !== 1'b0 || ack !== '0) valid_seen = 1'b1;
    end
    chk("mr_quiet", 32'(valid_seen), 32'(0));
    run_word(1, 16'hA000, 13, 1, 14);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
